hilo_mult_unit: RTL and testbench

//  Multi-cycle multiply/accumulate unit with the architectural HI/LO registers, downstream of the ALU control decoder.

---
 rtl/alu_ctrl_pkg.sv | 22 ++
 rtl/mult_seq_core.sv | 40 ++++
 rtl/hilo_mult_unit.sv | 97 +++++++++
 tb/tb_hilo_mult_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// ALU control codes shared with the decoder, plus the HI/LO multiply FSM encoding.
package alu_ctrl_pkg;

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_MULT  = 5'b00011;
  localparam logic [4:0] ALU_MULTU = 5'b00100;
  localparam logic [4:0] ALU_MUL   = 5'b10011;
  localparam logic [4:0] ALU_MADD  = 5'b10100;
  localparam logic [4:0] ALU_MSUB  = 5'b10101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_ACC  = 2'd2
  } mult_state_t;

  function automatic logic is_mult_op(input logic [4:0] code);
    return (code == ALU_MULT) || (code == ALU_MULTU) || (code == ALU_MUL) ||
           (code == ALU_MADD) || (code == ALU_MSUB);
  endfunction

endpackage

// File: rtl/mult_seq_core.sv
// Unsigned WIDTH x WIDTH radix-2 shift-add multiplier; one partial product per step.
module mult_seq_core #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mcand_in,
  input  logic [WIDTH-1:0]     mplier_in,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   sum;

  // Multiplier sits in the low half and is consumed LSB-first as the product shifts in.
  assign sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign last = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      prod  <= '0;
      count <= '0;
    end else if (load) begin
      mcand <= mcand_in;
      prod  <= {{WIDTH{1'b0}}, mplier_in};
      count <= '0;
    end else if (step) begin
      prod  <= {sum, prod[WIDTH-1:1]};
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hilo_mult_unit.sv
// Multi-cycle MULT/MULTU/MUL/MADD/MSUB unit owning the architectural HI/LO registers.
module hilo_mult_unit
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [4:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] MulResult,
  output logic             Busy,
  output logic             Done
);

  mult_state_t        state;
  logic [4:0]         op;
  logic               sign;
  logic               start_ok;
  logic               signed_op;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] hilo;
  logic               core_last;

  assign start_ok  = (state == ST_IDLE) && Start && is_mult_op(ALUControl);
  assign signed_op = (ALUControl != ALU_MULTU);
  // Negating the most negative value yields the correct unsigned magnitude.
  assign mag_a     = (signed_op && A[WIDTH-1]) ? (~A + 1'b1) : A;
  assign mag_b     = (signed_op && B[WIDTH-1]) ? (~B + 1'b1) : B;
  assign p         = sign ? (~prod + 1'b1) : prod;
  assign hilo      = {Hi, Lo};

  mult_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk       (Clk),
    .rst_n     (Rst),
    .load      (start_ok),
    .step      (state == ST_CALC),
    .mcand_in  (mag_a),
    .mplier_in (mag_b),
    .prod      (prod),
    .last      (core_last)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= ST_IDLE;
      op        <= '0;
      sign      <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
      MulResult <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (HiWrite) Hi <= WrData;
          if (LoWrite) Lo <= WrData;
          if (start_ok) begin
            op    <= ALUControl;
            sign  <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
            Busy  <= 1'b1;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (core_last) state <= ST_ACC;
        end
        ST_ACC: begin
          case (op)
            ALU_MULT, ALU_MULTU: {Hi, Lo} <= p;
            ALU_MADD:            {Hi, Lo} <= hilo + p;
            ALU_MSUB:            {Hi, Lo} <= hilo - p;
            ALU_MUL:             MulResult <= p[WIDTH-1:0];
            default:             ;
          endcase
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Self-checking bench: arithmetic reference model with cycle-level compare, directed and random ops.
module tb_hilo_mult_unit;
  localparam int W = 32;
  localparam logic [4:0] C_ADD = 5'b00000, C_MULT = 5'b00011, C_MULTU = 5'b00100,
                         C_MUL = 5'b10011, C_MADD = 5'b10100, C_MSUB = 5'b10101;

  logic Clk = 0, Rst = 0, Start = 0, HiWrite = 0, LoWrite = 0;
  logic [4:0] ALUControl = '0;
  logic [W-1:0] A = '0, B = '0, WrData = '0;
  logic [W-1:0] Hi, Lo, MulResult;
  logic Busy, Done;

  int checks = 0, errors = 0;
  bit cmp_en = 0;

  hilo_mult_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .ALUControl(ALUControl), .A(A), .B(B),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WrData(WrData),
    .Hi(Hi), .Lo(Lo), .MulResult(MulResult), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Reference model: operation result from 64-bit arithmetic, latency as a cycle countdown.
  logic [W-1:0] m_hi, m_lo, m_mul;
  logic m_busy, m_done;
  logic [4:0] m_op;
  logic [63:0] m_prod;
  int m_rem;

  function automatic logic is_mult(input logic [4:0] c);
    return c == C_MULT || c == C_MULTU || c == C_MUL || c == C_MADD || c == C_MSUB;
  endfunction

  function automatic logic [63:0] ref_prod(input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    if (c == C_MULTU) return {32'b0, a} * {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_hi = 0; m_lo = 0; m_mul = 0; m_busy = 0; m_done = 0; m_rem = 0; m_op = 0; m_prod = 0;
    end else begin
      m_done = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          case (m_op)
            C_MULT, C_MULTU: {m_hi, m_lo} = m_prod;
            C_MADD: {m_hi, m_lo} = {m_hi, m_lo} + m_prod;
            C_MSUB: {m_hi, m_lo} = {m_hi, m_lo} - m_prod;
            default: m_mul = m_prod[W-1:0];
          endcase
          m_busy = 0;
          m_done = 1;
        end
      end else begin
        if (HiWrite) m_hi = WrData;
        if (LoWrite) m_lo = WrData;
        if (Start && is_mult(ALUControl)) begin
          m_op = ALUControl;
          m_prod = ref_prod(ALUControl, A, B);
          m_rem = W + 1;
          m_busy = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("hi", 64'(Hi), 64'(m_hi));
      chk("lo", 64'(Lo), 64'(m_lo));
      chk("mulresult", 64'(MulResult), 64'(m_mul));
      chk("busy", 64'(Busy), 64'(m_busy));
      chk("done", 64'(Done), 64'(m_done));
    end
  end

  // Issues one op (optionally with a same-cycle HI/LO write) and returns edges from Start to Done.
  task automatic do_op(input logic [4:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic wh, input logic wl, input logic [W-1:0] wd, output int lat);
    @(negedge Clk);
    Start = 1; ALUControl = code; A = a; B = b; HiWrite = wh; LoWrite = wl; WrData = wd;
    @(posedge Clk); #1;
    Start = 0; HiWrite = 0; LoWrite = 0;
    ALUControl = 5'($urandom); A = $urandom; B = $urandom; WrData = $urandom;
    lat = 0;
    while (!Done && lat < 100) begin
      @(posedge Clk); #1;
      lat++;
    end
    if (lat >= 100) chk("done_timeout", 64'(lat), 64'(W + 1));
  endtask

  task automatic wr(input logic wh, input logic wl, input logic [W-1:0] wd);
    @(negedge Clk);
    HiWrite = wh; LoWrite = wl; WrData = wd;
    @(posedge Clk); #1;
    HiWrite = 0; LoWrite = 0;
  endtask

  initial begin
    int lat, pulses, busy_seen;
    logic [4:0] codes [5];
    codes[0] = C_MULT; codes[1] = C_MULTU; codes[2] = C_MUL; codes[3] = C_MADD; codes[4] = C_MSUB;

    repeat (2) @(posedge Clk);
    #1;
    chk("reset_hi", 64'(Hi), 0);
    chk("reset_busy", 64'(Busy), 0);
    @(negedge Clk);
    Rst = 1;
    cmp_en = 1;

    // 1: MULTU max*max and fixed latency
    do_op(C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, lat);
    chk("t1_latency_rise", 64'(lat), 64'(W + 1));
    chk("t1_hi", 64'(Hi), 64'hFFFFFFFE);
    chk("t1_lo", 64'(Lo), 64'h00000001);
    @(posedge Clk); #1;
    chk("t1_done_fall", 64'(Done), 0);

    // 2: signed MULT
    do_op(C_MULT, -32'sd3, 32'd5, 0, 0, 0, lat);
    chk("t2a_hi", 64'(Hi), 64'hFFFFFFFF);
    chk("t2a_lo", 64'(Lo), 64'hFFFFFFF1);
    do_op(C_MULT, 32'h80000000, 32'h80000000, 0, 0, 0, lat);  // back-to-back in Done cycle
    chk("t2b_hi", 64'(Hi), 64'h40000000);
    chk("t2b_lo", 64'(Lo), 64'h0);

    // 3: MADD / MSUB on written HI/LO
    wr(0, 1, 32'd10);
    wr(1, 0, 32'd0);
    do_op(C_MADD, 32'd4, 32'd5, 0, 0, 0, lat);
    chk("t3_madd_hi", 64'(Hi), 64'h0);
    chk("t3_madd_lo", 64'(Lo), 64'd30);
    wr(0, 1, 32'd10);
    do_op(C_MSUB, 32'd4, 32'd5, 0, 0, 0, lat);
    chk("t3_msub_hi", 64'(Hi), 64'hFFFFFFFF);
    chk("t3_msub_lo", 64'(Lo), 64'hFFFFFFF6);

    // 4: MUL leaves HI/LO alone
    do_op(C_MUL, 32'd7, -32'sd6, 0, 0, 0, lat);
    chk("t4_mulresult", 64'(MulResult), 64'hFFFFFFD6);
    chk("t4_hi_kept", 64'(Hi), 64'hFFFFFFFF);
    chk("t4_lo_kept", 64'(Lo), 64'hFFFFFFF6);

    // both writes in one cycle, then write in the Start cycle feeding MADD
    wr(1, 1, 32'h12345678);
    chk("both_wr_hi", 64'(Hi), 64'h12345678);
    chk("both_wr_lo", 64'(Lo), 64'h12345678);
    wr(1, 0, 32'd0);
    do_op(C_MADD, 32'd2, 32'd3, 0, 1, 32'd100, lat);
    chk("start_wr_lo", 64'(Lo), 64'd106);
    chk("start_wr_hi", 64'(Hi), 64'd0);

    // 5: Start and HiWrite while busy are ignored
    @(negedge Clk);
    Start = 1; ALUControl = C_MULT; A = -32'sd3; B = 32'd5;
    @(posedge Clk); #1;
    Start = 0;
    pulses = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge Clk);
      Start = (c == 5); HiWrite = (c == 10);
      A = 32'd100; B = 32'd100; WrData = 32'hDEADBEEF;
      @(posedge Clk); #1;
      Start = 0; HiWrite = 0;
      if (Done) pulses++;
    end
    chk("t5_done_pulses", 64'(pulses), 1);
    chk("t5_hi", 64'(Hi), 64'hFFFFFFFF);
    chk("t5_lo", 64'(Lo), 64'hFFFFFFF1);

    // random ops with optional same-cycle writes
    for (int i = 0; i < 30; i++) begin
      do_op(codes[$urandom_range(0, 4)], $urandom, $urandom,
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), $urandom, lat);
      chk("rand_latency", 64'(lat), 64'(W + 1));
    end

    // 6: async reset mid-op, then a non-multiply Start
    @(negedge Clk);
    Start = 1; ALUControl = C_MULT; A = 32'h7FFFFFFF; B = 32'h7FFFFFFF;
    @(posedge Clk); #1;
    Start = 0;
    repeat (15) @(posedge Clk);
    #2;
    Rst = 0;
    #1;
    chk("t6_hi", 64'(Hi), 0);
    chk("t6_lo", 64'(Lo), 0);
    chk("t6_mulresult", 64'(MulResult), 0);
    chk("t6_busy", 64'(Busy), 0);
    chk("t6_done", 64'(Done), 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1;
    @(negedge Clk);
    Start = 1; ALUControl = C_ADD; A = 32'd3; B = 32'd4;
    @(posedge Clk); #1;
    Start = 0;
    busy_seen = 0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Busy || Done) busy_seen++;
    end
    chk("t6_add_ignored", 64'(busy_seen), 0);

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
